// File: rtl/wormhole_output_arbiter.sv
// Per-output-port switch allocator for the wormhole router: round-robin arbitration
// among heads routed here, then a head-to-tail lock that pops the winner's buffer.
module wormhole_output_arbiter #(
  parameter int unsigned N_PORTS = 5,
  parameter int unsigned FLIT_W  = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          req,
  input  logic [N_PORTS*FLIT_W-1:0]   flit_in,
  input  logic                        downstream_on,
  output logic [N_PORTS-1:0]          pop,
  output logic [N_PORTS-1:0]          grant,
  output logic [FLIT_W-1:0]           flit_out,
  output logic                        flit_valid,
  output logic                        err
);

  localparam int unsigned PTR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [1:0]  T_HEAD = 2'b10;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [N_PORTS-1:0]   grant_d;
  logic [FLIT_W-1:0]    flit_out_d;
  logic                 flit_valid_d;
  logic                 err_d;

  logic [N_PORTS-1:0]   eligible;
  logic [N_PORTS-1:0]   misroute;
  logic [PTR_W-1:0]     winner;
  logic                 any_eligible;
  logic [FLIT_W-1:0]    owner_flit;
  logic [1:0]           owner_type;
  logic                 owner_req;

  // Type bit 1 set means HEAD or SINGLE; clear means BODY or TAIL.
  always_comb begin
    eligible = '0;
    misroute = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      eligible[i] = req[i] &  flit_in[i*FLIT_W + FLIT_W - 1];
      misroute[i] = req[i] & ~flit_in[i*FLIT_W + FLIT_W - 1];
    end
  end

  // Round-robin search starting at rr_ptr.
  always_comb begin
    int unsigned idx;
    idx          = 0;
    winner       = '0;
    any_eligible = 1'b0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      idx = (32'(rr_ptr_q) + k) % N_PORTS;
      if (!any_eligible && eligible[idx]) begin
        any_eligible = 1'b1;
        winner       = PTR_W'(idx);
      end
    end
  end

  // Front flit and request of the current owner.
  always_comb begin
    owner_flit = '0;
    owner_req  = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (owner_q == PTR_W'(i)) begin
        owner_flit = flit_in[i*FLIT_W +: FLIT_W];
        owner_req  = req[i];
      end
    end
    owner_type = owner_flit[FLIT_W-1:FLIT_W-2];
  end

  // Next-state and pop logic.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    grant_d      = grant;
    flit_out_d   = flit_out;
    flit_valid_d = 1'b0;
    err_d        = 1'b0;
    pop          = '0;
    case (state_q)
      IDLE: begin
        err_d = |misroute;
        if (any_eligible) begin
          owner_d          = winner;
          grant_d          = '0;
          grant_d[winner]  = 1'b1;
          state_d          = LOCKED;
        end
      end
      LOCKED: begin
        if (owner_req && downstream_on) begin
          pop[owner_q] = 1'b1;
          flit_valid_d = 1'b1;
          flit_out_d   = owner_flit;
          // Type bit 0 set means TAIL or SINGLE: release the lock.
          if (owner_type[0]) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = (owner_q == PTR_W'(N_PORTS - 1)) ? '0 : owner_q + PTR_W'(1);
          end else if (owner_type == T_HEAD) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) pop = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      grant      <= '0;
      flit_out   <= '0;
      flit_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      grant      <= grant_d;
      flit_out   <= flit_out_d;
      flit_valid <= flit_valid_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_wormhole_output_arbiter.sv
// Randomized bench: per-input flit queues act as the input buffers, and a packet-level
// model predicts pops, grants, forwarded flits and error pulses cycle by cycle.
module tb_wormhole_output_arbiter;

  localparam int N = 5;
  localparam int W = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   flit_in;
  logic             downstream_on;
  logic [N-1:0]     pop;
  logic [N-1:0]     grant;
  logic [W-1:0]     flit_out;
  logic             flit_valid;
  logic             err;

  always #5 clk = ~clk;

  wormhole_output_arbiter #(.N_PORTS(N), .FLIT_W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .flit_in       (flit_in),
    .downstream_on (downstream_on),
    .pop           (pop),
    .grant         (grant),
    .flit_out      (flit_out),
    .flit_valid    (flit_valid),
    .err           (err)
  );

  logic [W-1:0] q [N][$];
  logic [N-1:0] bubble;
  int errors = 0;
  int checks = 0;

  // Reference model: owner -1 means no packet in progress.
  int           m_owner = -1;
  int           m_ptr   = 0;
  logic [N-1:0] m_grant = '0;
  logic         m_fv    = 1'b0;
  logic         m_err   = 1'b0;
  logic [W-1:0] m_fo    = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] t, input int src);
    return {t, 30'(src), 32'($urandom)};
  endfunction

  task automatic push_pkt(input int src, input int len);
    if (len == 1) q[src].push_back(mk(2'b11, src));
    else begin
      q[src].push_back(mk(2'b10, src));
      for (int b = 0; b < len - 2; b++) q[src].push_back(mk(2'b00, src));
      q[src].push_back(mk(2'b01, src));
    end
  endtask

  task automatic step(input logic r, input logic on);
    logic [N-1:0] exp_pop;
    logic [W-1:0] f;
    int           o;
    @(negedge clk);
    rst           = r;
    downstream_on = on;
    for (int i = 0; i < N; i++) begin
      req[i]            = (q[i].size() > 0) && !bubble[i];
      flit_in[i*W +: W] = (q[i].size() > 0) ? q[i][0] : '0;
    end
    #1;
    exp_pop = '0;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_grant = '0; m_fv = 1'b0; m_fo = '0; m_err = 1'b0;
    end else if (m_owner < 0) begin
      m_fv  = 1'b0;
      m_err = 1'b0;
      for (int i = 0; i < N; i++) begin
        f = flit_in[i*W +: W];
        if (req[i] && (f[W-1:W-2] == 2'b00 || f[W-1:W-2] == 2'b01)) m_err = 1'b1;
      end
      for (int k = 0; k < N; k++) begin
        o = (m_ptr + k) % N;
        f = flit_in[o*W +: W];
        if (req[o] && (f[W-1:W-2] == 2'b10 || f[W-1:W-2] == 2'b11)) begin
          m_owner    = o;
          m_grant    = '0;
          m_grant[o] = 1'b1;
          break;
        end
      end
    end else begin
      m_fv  = 1'b0;
      m_err = 1'b0;
      if (req[m_owner] && on) begin
        exp_pop[m_owner] = 1'b1;
        m_fv = 1'b1;
        m_fo = q[m_owner].pop_front();
        if (m_fo[W-1:W-2] == 2'b01 || m_fo[W-1:W-2] == 2'b11) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_grant = '0;
        end else if (m_fo[W-1:W-2] == 2'b10) begin
          m_err = 1'b1;
        end
      end
    end
    check("pop", 64'(pop), 64'(exp_pop));
    @(posedge clk);
    #1;
    check("grant", 64'(grant), 64'(m_grant));
    check("flit_valid", 64'(flit_valid), 64'(m_fv));
    check("flit_out", flit_out, m_fo);
    check("err", 64'(err), 64'(m_err));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bubble = '0; rst = 1'b1; req = '0; flit_in = '0; downstream_on = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // Single-flit packet on input 2.
    push_pkt(2, 1);
    repeat (4) step(1'b0, 1'b1);

    // Two 3-flit packets from inputs 0 and 3 with pointer at 0.
    step(1'b1, 1'b1);
    push_pkt(0, 3);
    push_pkt(3, 3);
    repeat (10) step(1'b0, 1'b1);

    // Downstream off for 4 cycles mid-packet.
    push_pkt(1, 6);
    repeat (3) step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);
    repeat (7) step(1'b0, 1'b1);

    // All inputs streaming singles: rotation with pointer wrap.
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < N; i++) if (q[i].size() == 0) push_pkt(i, 1);
      step(1'b0, 1'b1);
    end
    for (int i = 0; i < N; i++) q[i].delete();
    repeat (3) step(1'b0, 1'b1);

    // Reset while locked on input 1 after H and B were popped.
    push_pkt(1, 3);
    for (int c = 0; c < 10 && !(m_owner == 1 && q[1].size() == 1); c++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    q[1].delete();
    push_pkt(1, 3);
    repeat (6) step(1'b0, 1'b1);

    // BODY at the front of an idle input.
    q[2].push_back(mk(2'b00, 2));
    step(1'b0, 1'b1);
    q[2].delete();
    step(1'b0, 1'b1);

    // Second HEAD inside a locked packet.
    q[4].push_back(mk(2'b10, 4));
    q[4].push_back(mk(2'b10, 4));
    q[4].push_back(mk(2'b01, 4));
    repeat (6) step(1'b0, 1'b1);

    // Random traffic with bubbles, backpressure and occasional reset.
    for (int c = 0; c < 2000; c++) begin
      logic r;
      for (int i = 0; i < N; i++)
        if (q[i].size() == 0 && ($urandom % 4) == 0) push_pkt(i, 1 + int'($urandom % 4));
      bubble = N'($urandom) & N'($urandom);
      r = (($urandom % 250) == 0);
      step(r, (($urandom % 5) != 0));
      if (r) for (int i = 0; i < N; i++) q[i].delete();
    end
    bubble = '0;
    repeat (40) step(1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
